// File: rtl/aux_uart_pkg.sv
// Shared definitions for the aux UART transmitter and receiver.
package aux_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud_hz);
    return (clk_hz + baud_hz / 2) / baud_hz;
  endfunction

endpackage

// File: rtl/aux_uart_fifo.sv
// Synchronous byte FIFO; pop_data is registered and valid the cycle after a pop.
module aux_uart_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage array; no reset so it maps onto plain registers or a small RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        pop_data <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aux_uart_tx.sv
// Aux UART transmitter: valid/ready byte input, FIFO buffer, 8N1 serialiser.
module aux_uart_tx
  import aux_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV   = baud_div(CLK_FREQUENCY, BAUD_RATE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_c;
  logic             pop;
  logic             push;
  logic             bit_end;
  logic [7:0]       pop_data;
  logic             fifo_full;
  logic             fifo_empty;

  // A full FIFO still takes a byte on the edge where the serialiser pops one.
  assign push     = wr_valid & (~fifo_full | pop);
  assign wr_ready = ~fifo_full;
  assign busy     = (state_q != IDLE) | (fifo_count != '0);
  assign bit_end  = (baud_q == CNT_W'(DIV - 1));

  aux_uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State, baud counter, shifter and the tx pin flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx        <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx        <= tx_c;
    end
  end

  // Next-state, pop request and line level for the current bit.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_c      = 1'b1;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_c = 1'b0;
        // Popped byte lands in pop_data one cycle after the pop.
        if (baud_q == '0) shift_d = pop_data;
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_c = shift_q[0];
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        tx_c = 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aux_uart_tx.sv
// Randomised bench for aux_uart_tx against a frame-level reference model.
module tb_aux_uart_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 90_000;
  localparam int unsigned DEPTH  = 16;
  localparam int          DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int          FRAME  = 10 * DIV;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int checks;
  int failures;

  // Reference model: byte queue plus timing of the most recent frame.
  logic [7:0] q[$];
  int         r_left;
  longint     cyc;
  longint     p_edge;
  logic [7:0] p_byte;
  bit         have_frame;

  aux_uart_tx #(
    .CLK_FREQUENCY (CLK_HZ),
    .BAUD_RATE     (BAUD),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic frame_level(input longint k, input logic [7:0] b);
    longint idx;
    idx = k / DIV;
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= 8) return b[int'(idx) - 1];
    return 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    r_left     = 0;
    have_frame = 1'b0;
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare after it.
  task automatic step(input logic v, input logic [7:0] d);
    bit   pop_now;
    bit   push_now;
    logic exp_tx;
    wr_valid = v;
    wr_data  = d;
    pop_now  = (q.size() > 0) && (r_left <= 1);
    push_now = v && ((q.size() < DEPTH) || pop_now);
    cyc++;
    exp_tx = have_frame ? frame_level(cyc - p_edge - 1, p_byte) : 1'b1;
    if (pop_now) begin
      p_byte     = q.pop_front();
      p_edge     = cyc;
      have_frame = 1'b1;
      r_left     = FRAME;
    end else if (r_left > 0) begin
      r_left--;
    end
    if (push_now) q.push_back(d);
    @(posedge clk);
    #1;
    check_eq("tx", 32'(tx), 32'(exp_tx));
    check_eq("busy", 32'(busy), 32'((r_left > 0) || (q.size() > 0)));
    check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
    check_eq("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    bit reached;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    p_edge   = 0;
    p_byte   = 8'h00;
    model_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Quiet line after reset.
    idle(10 * DIV);

    // Single byte.
    step(1'b1, 8'h55);
    idle(FRAME + 5);

    // Three back-to-back bytes form contiguous frames.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    idle(3 * FRAME + 5);

    // Start a frame, then offer 17 bytes: the 17th must be dropped.
    step(1'b1, 8'($urandom));
    step(1'b0, 8'h00);
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom));
    idle(5);
    check_eq("full_count", 32'(fifo_count), 32'(DEPTH));

    // Keep offering while full: only pop edges accept a byte.
    for (int i = 0; i < 3 * FRAME; i++) step(1'b1, 8'($urandom));
    check_eq("full_hold_count", 32'(fifo_count), 32'(DEPTH));
    idle((DEPTH + 2) * FRAME);

    // Random traffic at a few densities.
    for (int phase = 0; phase < 3; phase++) begin
      int pct;
      pct = (phase == 0) ? 2 : (phase == 1) ? 8 : 40;
      for (int i = 0; i < 1500; i++)
        step(($urandom_range(0, 99) < pct), 8'($urandom));
    end
    idle((DEPTH + 2) * FRAME);

    // Reset in the middle of data bit 3 (a 0 bit, so the pin visibly jumps high).
    step(1'b1, 8'hF0);
    step(1'b1, 8'h3C);
    reached = 1'b0;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      if (have_frame && (cyc - p_edge - 1) == 4 * DIV + DIV / 2) reached = 1'b1;
      else step(1'b0, 8'h00);
    end
    check_eq("bit3_reached", 32'(reached), 32'd1);
    check_eq("pre_reset_tx", 32'(tx), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_tx", 32'(tx), 32'd1);
    check_eq("async_rst_count", 32'(fifo_count), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(3 * FRAME);

    wr_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
